mfp_sevenseg_scanner: RTL and testbench
=======================================

Name: mfp_sevenseg_scanner

Overview:
- Time-multiplexed driver for the board 7-segment display.
- Takes the 32-bit 7-segment GPIO register value as 8 hex nibbles and scans one digit at a time onto shared segment lines plus per-digit anode enables.
- Sits between the GPIO map's 7-segment register output and the board pins.
- Provides frame-coherent sampling, anti-ghosting guard time, decimal-point and blank masks, and leading-zero suppression.

Parameters:
DIGIT_COUNT, 8, number of digits scanned; the value input is DIGIT_COUNT*4 bits wide.
DIGIT_PERIOD, 50000, clk cycles each digit slot lasts; must be at least 2.
GUARD_CYCLES, 8, cycles at the start of each slot with all anodes off; must be at least 1 and less than DIGIT_PERIOD.
ANODE_ACTIVE_LOW, 1, 1 means an active anode is driven 0.
SEG_ACTIVE_LOW, 1, 1 means a lit segment or dp is driven 0.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scan running; 0 = display dark and counters cleared
value  input  DIGIT_COUNT*4  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost
dp_mask  input  DIGIT_COUNT  bit i lights the decimal point of digit i
blank_mask  input  DIGIT_COUNT  bit i forces digit i dark (segments and dp)
lz_suppress  input  1  1 = blank leading zero digits
anodes  output  DIGIT_COUNT  per-digit enables, polarity per ANODE_ACTIVE_LOW
segments  output  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW
frame_tick  output  1  one-cycle pulse when the shadow registers load

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - Slot counter cnt = 0; digit index idx = 0.
  - All shadow registers = 0.
  - anodes all inactive; segments and dp unlit (polarity applied); frame_tick = 0.
- Counting (enable = 1):
  - cnt increments each cycle.
  - When cnt == DIGIT_PERIOD-1, cnt wraps to 0 and idx advances.
  - idx wraps from DIGIT_COUNT-1 to 0.
- Counting (enable = 0): cnt and idx are held at 0; all outputs are driven to reset values on the next edge.
- Shadow load:
  - Occurs in any cycle with enable = 1, idx == 0 and cnt == 0.
  - value, dp_mask, blank_mask and lz_suppress are copied into shadow registers.
  - The registered frame_tick is 1 in the following cycle.
  - Input changes mid-frame are not visible until the next frame. There is no tearing.
- Leading-zero suppression, evaluated on shadow values:
  - Digit i is suppressed when lz_suppress = 1, i > 0, and all nibbles i..DIGIT_COUNT-1 are zero.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows dp if its dp_mask bit is set.
- Hex font, active-high form {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Output registration: all outputs are registered. Values computed from (idx, cnt, shadow) in cycle N appear in cycle N+1.
- Guard: while cnt < GUARD_CYCLES, anodes are all inactive and segments/dp unlit.
- Active part of slot: otherwise exactly one anode (bit idx) is active.
  - segments = font(shadow nibble idx), or unlit if the digit is blanked or suppressed.
  - dp = shadow dp_mask[idx], unless blanked.
- Polarity: inversion is applied last, after blank/suppress logic.
- Enable toggling:
  - Deassertion mid-slot takes effect next cycle (display dark).
  - Reassertion restarts at idx 0, cnt 0, with an immediate shadow load.
- Reset mid-operation: all state returns to reset values asynchronously. The first cycle after release with enable = 1 performs a shadow load.
- Guard and output-register latency mean shadow-update cycles never drive a lit anode.

Test Plan:
- Reset value check. DIGIT_COUNT=8, DIGIT_PERIOD=4, GUARD=1, active-low both. Hold rst_n=0 → anodes=8'hFF, segments=7'h7F, dp=1.
- Full frame scan. Release with enable=1, value=32'h89ABCDEF, masks 0.
  - frame_tick pulses in cycle 1, and every 32 cycles thereafter.
  - Each slot shows 1 guard cycle of anodes=FF, then 3 cycles of one active anode.
  - Slot 0: anodes=FE, segments=~1110001 (F).
  - Slot 7: anodes=7F, segments=~1111111 (8).
- Mid-frame input change. Change value to 0 during slot 3 → slots 3–7 still show the old digits; the next frame shows 0 in all slots.
- Leading-zero suppression. value=32'h00000120, lz_suppress=1, dp_mask=8'h80.
  - Digits 0–2 show 0,2,1.
  - Digits 3–6 are dark.
  - Digit 7 shows only dp=0, with segments=7F.
- Masks and enable. blank_mask=8'h01 → digit 0 is fully dark. Drop enable during slot 5 → next cycle anodes=FF. Re-raise enable → frame_tick pulses and the scan restarts at digit 0.
- Async reset mid-slot. Assert rst_n=0 mid-slot → outputs dark immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mfp_sevenseg_scanner.sv
// Time-multiplexed 7-segment scanner: samples a frame of hex digits and masks at frame
// start, then drives one digit per slot with a dark guard interval before each anode turns on.
module mfp_sevenseg_scanner #(
    parameter int unsigned DIGIT_COUNT      = 8,
    parameter int unsigned DIGIT_PERIOD     = 50000,
    parameter int unsigned GUARD_CYCLES     = 8,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [DIGIT_COUNT*4-1:0] value,
    input  logic [DIGIT_COUNT-1:0]   dp_mask,
    input  logic [DIGIT_COUNT-1:0]   blank_mask,
    input  logic                     lz_suppress,
    output logic [DIGIT_COUNT-1:0]   anodes,
    output logic [6:0]               segments,
    output logic                     dp,
    output logic                     frame_tick
);

    localparam int unsigned VAL_W = DIGIT_COUNT * 4;
    localparam int unsigned CNT_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int unsigned IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

    localparam logic [DIGIT_COUNT-1:0] ANODE_OFF = {DIGIT_COUNT{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]             SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic                   DP_OFF    = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [VAL_W-1:0]       sh_value;
    logic [DIGIT_COUNT-1:0] sh_dp;
    logic [DIGIT_COUNT-1:0] sh_blank;
    logic                   sh_lz;

    logic                   load_c;
    logic                   cnt_last_c;
    logic                   idx_last_c;
    logic [DIGIT_COUNT-1:0] lz_mask_c;
    logic [3:0]             nib_c;
    logic [DIGIT_COUNT-1:0] anodes_c;
    logic [6:0]             segments_c;
    logic                   dp_c;

    // Hex font, active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0:    font = 7'b0111111;
            4'h1:    font = 7'b0000110;
            4'h2:    font = 7'b1011011;
            4'h3:    font = 7'b1001111;
            4'h4:    font = 7'b1100110;
            4'h5:    font = 7'b1101101;
            4'h6:    font = 7'b1111101;
            4'h7:    font = 7'b0000111;
            4'h8:    font = 7'b1111111;
            4'h9:    font = 7'b1101111;
            4'hA:    font = 7'b1110111;
            4'hB:    font = 7'b1111100;
            4'hC:    font = 7'b0111001;
            4'hD:    font = 7'b1011110;
            4'hE:    font = 7'b1111001;
            default: font = 7'b1110001;
        endcase
    endfunction

    // Next-cycle display image from slot position and shadow state
    always_comb begin
        logic run;
        load_c     = enable && (idx == '0) && (cnt == '0);
        cnt_last_c = (cnt == CNT_W'(DIGIT_PERIOD - 1));
        idx_last_c = (idx == IDX_W'(DIGIT_COUNT - 1));
        nib_c      = sh_value[{idx, 2'b00} +: 4];
        anodes_c   = '0;
        segments_c = '0;
        dp_c       = 1'b0;
        lz_mask_c  = '0;

        // A digit is a leading zero when it and every digit above it are zero
        run = 1'b1;
        for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
            run          = run && (sh_value[i*4 +: 4] == 4'h0);
            lz_mask_c[i] = sh_lz && (i > 0) && run;
        end

        if (enable && (cnt >= CNT_W'(GUARD_CYCLES))) begin
            anodes_c = DIGIT_COUNT'(1) << idx;
            if (!sh_blank[idx]) begin
                dp_c = sh_dp[idx];
                if (!lz_mask_c[idx]) begin
                    segments_c = font(nib_c);
                end
            end
        end

        anodes_c   = anodes_c ^ ANODE_OFF;
        segments_c = segments_c ^ SEG_OFF;
        dp_c       = dp_c ^ DP_OFF;
    end

    // Slot counters, frame shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            anodes     <= ANODE_OFF;
            segments   <= SEG_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            if (!enable) begin
                cnt <= '0;
                idx <= '0;
            end else if (cnt_last_c) begin
                cnt <= '0;
                idx <= idx_last_c ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (load_c) begin
                sh_value <= value;
                sh_dp    <= dp_mask;
                sh_blank <= blank_mask;
                sh_lz    <= lz_suppress;
            end

            anodes     <= anodes_c;
            segments   <= segments_c;
            dp         <= dp_c;
            frame_tick <= load_c;
        end
    end

endmodule

// File: tb/tb_mfp_sevenseg_scanner.sv
// Scoreboard bench for mfp_sevenseg_scanner: stimulus queues hand-computed display images
// per cycle; a negedge monitor pops and compares them against the pins.
module tb_mfp_sevenseg_scanner;

    localparam int unsigned DC = 8;
    localparam int unsigned DPER = 4;
    localparam int unsigned GC = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b1;
    logic [31:0]   value = 32'h0;
    logic [7:0]    dp_mask = 8'h0;
    logic [7:0]    blank_mask = 8'h0;
    logic          lz_suppress = 1'b0;
    logic [7:0]    anodes;
    logic [6:0]    segments;
    logic          dp;
    logic          frame_tick;

    mfp_sevenseg_scanner #(
        .DIGIT_COUNT(DC),
        .DIGIT_PERIOD(DPER),
        .GUARD_CYCLES(GC),
        .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .value(value),
        .dp_mask(dp_mask),
        .blank_mask(blank_mask),
        .lz_suppress(lz_suppress),
        .anodes(anodes),
        .segments(segments),
        .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       d;
        logic       ft;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    // Per-slot expected segments/dp for the frame on screen and the one queued next
    logic [6:0] cur_seg[8];
    logic       cur_dp[8];
    logic [6:0] next_seg[8];
    logic       next_dp[8];

    // Monitor: compares every expectation tagged for the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.tag != cyc) begin
                errors++;
                $display("FAIL %s stale tag=%0d now=%0d", mon_e.name, mon_e.tag, cyc);
            end else if ({anodes, segments, dp, frame_tick} !== {mon_e.an, mon_e.seg, mon_e.d, mon_e.ft}) begin
                errors++;
                $display("FAIL %s got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         mon_e.name, anodes, segments, dp, frame_tick,
                         mon_e.an, mon_e.seg, mon_e.d, mon_e.ft);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] an, input logic [6:0] seg,
                              input logic d, input logic ft);
        exp_t e;
        e.tag = cyc;
        e.an = an;
        e.seg = seg;
        e.d = d;
        e.ft = ft;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic expect_dark(input string nm, input logic ft);
        expect_out(nm, 8'hFF, 7'h7F, 1'b1, ft);
    endtask

    // k counts edges from the frame-load edge: phase 0 is guard, 1..3 light digit k/4
    task automatic exp_slot(input string nm, input int k, input logic ft);
        logic [7:0] an;
        int s;
        s = (k / 4) % 8;
        if (k % 4 == 0) begin
            expect_dark(nm, ft);
        end else begin
            an = 8'h01 << s;
            an = ~an;
            expect_out(nm, an, cur_seg[s], cur_dp[s], ft);
        end
    endtask

    task automatic set_next(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                            input logic [6:0] s6, input logic [6:0] s7, input logic [7:0] dpn);
        next_seg[0] = s0; next_seg[1] = s1; next_seg[2] = s2; next_seg[3] = s3;
        next_seg[4] = s4; next_seg[5] = s5; next_seg[6] = s6; next_seg[7] = s7;
        for (int i = 0; i < 8; i++) next_dp[i] = dpn[i];
    endtask

    task automatic take_next();
        for (int i = 0; i < 8; i++) begin
            cur_seg[i] = next_seg[i];
            cur_dp[i] = next_dp[i];
        end
    endtask

    initial begin
        value = 32'h89ABCDEF;
        // Active-low images of F,E,d,C,b,A,9,8 for slots 0..7
        set_next(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00, 8'hFF);
        take_next();

        #2 rst_n = 1'b0;
        step();
        step();
        expect_dark("reset", 1'b0);
        rst_n = 1'b1;

        for (int k = 0; k < 150; k++) begin
            step();
            if (k % 32 == 0) take_next();
            exp_slot($sformatf("scan k=%0d", k), k, (k % 32) == 0);
            if (k == 45) begin
                value = 32'h0;
                set_next(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 8'hFF);
            end
            if (k == 70) begin
                value = 32'h00000120;
                lz_suppress = 1'b1;
                dp_mask = 8'h80;
                set_next(7'h40, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'h7F);
            end
            if (k == 110) begin
                value = 32'h89ABCDEF;
                lz_suppress = 1'b0;
                dp_mask = 8'h01;
                blank_mask = 8'h01;
                set_next(7'h7F, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00, 8'hFF);
            end
        end

        // Drop enable mid slot 5
        enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            expect_dark($sformatf("en_off j=%0d", j), 1'b0);
        end

        enable = 1'b1;
        for (int j = 0; j < 7; j++) begin
            step();
            exp_slot($sformatf("restart j=%0d", j), j, j == 0);
        end

        // Asynchronous reset while digit 1 is lit
        step();
        rst_n = 1'b0;
        expect_dark("async_rst", 1'b0);
        step();
        expect_dark("rst_hold", 1'b0);
        rst_n = 1'b1;

        for (int j = 0; j < 6; j++) begin
            step();
            exp_slot($sformatf("post_rst j=%0d", j), j, j == 0);
        end

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
